// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle between the control FSM and the
// multiply/divide unit. The master (control FSM) drives start/op/a/b; the
// slave (mult_div_unit) returns hi/lo and the busy/done/dbz status.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             dbz;

    modport master (
        output start, op, a, b,
        input  hi, lo, busy, done, dbz
    );

    modport slave (
        input  start, op, a, b,
        output hi, lo, busy, done, dbz
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative WIDTH-bit multiply/divide for the EX stage.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// clock; signed ops run on magnitudes and are sign-corrected on the final
// write into HI/LO.
// Optional build macro MDU_EARLY_TERM_EN: multiplies leave CALC as soon as
// the remaining multiplier bits are all zero (divides unaffected).
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           rst,
    mult_div_unit_if.slave bus
);
    localparam logic [1:0]       S_IDLE   = 2'd0;
    localparam logic [1:0]       S_CALC   = 2'd1;
    localparam logic [1:0]       S_FIN    = 2'd2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // Control and datapath state. r_acc is shared: for multiply the upper
    // WIDTH+1 bits are the running partial product and the lower WIDTH bits
    // the unconsumed multiplier; for divide the upper part is the partial
    // remainder and the lower part the dividend shifting into the quotient.
    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH:0]   r_acc;
    logic [WIDTH-1:0]   r_opnd;      // |multiplicand| or |divisor|
    logic [WIDTH-1:0]   r_a_raw;     // unmodified a, returned in hi on divide-by-zero
    logic               r_is_div;
    logic               r_neg_lo;    // product sign, or quotient sign
    logic               r_neg_hi;    // remainder sign
    logic               r_dbz_pend;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;

    logic               w_signed;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_b_zero;
    logic [WIDTH:0]     w_madd;
    logic [2*WIDTH:0]   w_mstep;
    logic [WIDTH:0]     w_dshift;
    logic [WIDTH:0]     w_ddiff;
    logic [2*WIDTH:0]   w_dstep;
    logic [2*WIDTH-1:0] w_prod_align;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_et_exit;
    logic               w_et_zero;

    // Two's-complement negate when en is set.
    function automatic logic [WIDTH-1:0] f_neg_w(input logic [WIDTH-1:0] x, input logic en);
        return en ? (~x + WIDTH'(1)) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_neg_2w(input logic [2*WIDTH-1:0] x, input logic en);
        return en ? (~x + (2*WIDTH)'(1)) : x;
    endfunction

    // Magnitude of x, treating it as signed only for the signed ops.
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] x, input logic is_signed);
        return f_neg_w(x, is_signed & x[WIDTH-1]);
    endfunction

    assign w_signed = bus.op[0];
    assign w_sa     = w_signed & bus.a[WIDTH-1];
    assign w_sb     = w_signed & bus.b[WIDTH-1];
    assign w_mag_a  = f_mag(bus.a, w_signed);
    assign w_mag_b  = f_mag(bus.b, w_signed);
    assign w_b_zero = (bus.b == '0);

    // Single iteration of each algorithm, plus sign-corrected final results.
    always_comb begin
        w_madd   = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_mstep  = {1'b0, w_madd, r_acc[WIDTH-1:1]};
        w_dshift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_ddiff  = w_dshift - {1'b0, r_opnd};
        if (!w_ddiff[WIDTH]) begin
            w_dstep = {w_ddiff, r_acc[WIDTH-2:0], 1'b1};
        end else begin
            w_dstep = {w_dshift, r_acc[WIDTH-2:0], 1'b0};
        end
        w_prod = f_neg_2w(w_prod_align, r_neg_lo);
        w_quo  = f_neg_w(r_acc[WIDTH-1:0], r_neg_lo);
        w_rem  = f_neg_w(r_acc[2*WIDTH-1:WIDTH], r_neg_hi);
    end

`ifdef MDU_EARLY_TERM_EN
    logic [WIDTH-1:0] r_mrem;        // multiplier bits not yet consumed
    logic [CNT_W-1:0] w_shamt;

    // Shadow of the multiplier, shifted in step with the accumulator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mrem <= '0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_mrem <= w_mag_b;
        end else if (r_state == S_CALC) begin
            r_mrem <= r_mrem >> 1;
        end
    end

    // An early exit leaves the product WIDTH-1-r_cnt places too far left.
    assign w_shamt      = LAST_CNT - r_cnt;
    assign w_prod_align = r_acc[2*WIDTH-1:0] >> w_shamt;
    assign w_et_exit    = !r_is_div && (r_mrem[WIDTH-1:1] == '0);
    assign w_et_zero    = (w_mag_b == '0);
`else
    assign w_prod_align = r_acc[2*WIDTH-1:0];
    assign w_et_exit    = 1'b0;
    assign w_et_zero    = 1'b0;
`endif

    // Main FSM: IDLE latches operands, CALC iterates, FIN writes HI/LO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_a_raw    <= '0;
            r_is_div   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_a_raw  <= bus.a;
                        r_is_div <= bus.op[1];
                        r_neg_lo <= w_sa ^ w_sb;
                        r_neg_hi <= w_sa;
                        if (bus.op[1]) begin
                            r_opnd     <= w_mag_b;
                            r_acc      <= {{(WIDTH+1){1'b0}}, w_mag_a};
                            r_dbz_pend <= w_b_zero;
                            r_state    <= w_b_zero ? S_FIN : S_CALC;
                        end else begin
                            r_opnd     <= w_mag_a;
                            r_acc      <= {{(WIDTH+1){1'b0}}, w_mag_b};
                            r_dbz_pend <= 1'b0;
                            r_state    <= w_et_zero ? S_FIN : S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= r_is_div ? w_dstep : w_mstep;
                    if (r_cnt == LAST_CNT || w_et_exit) begin
                        r_state <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_dbz   <= r_dbz_pend;
                    if (r_dbz_pend) begin
                        r_hi <= r_a_raw;
                        r_lo <= '1;
                    end else if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.dbz  = r_dbz;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit. Expected HI/LO/dbz
// come from a 64-bit arithmetic reference and are queued at start; the
// monitor pops and compares on every done pulse.
module tb_mult_div_unit;
    logic clk;
    logic rst;
    mult_div_unit_if #(.WIDTH(32)) u_if ();

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference results from plain 64-bit arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        e.dbz = 1'b0;
        case (op)
            2'b00: begin
                p    = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                p    = sa * sb;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi  = a;
                    e.lo  = 32'hFFFF_FFFF;
                    e.dbz = 1'b1;
                end else if (op == 2'b10) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end else begin
                    p    = sa / sb;
                    e.lo = p[31:0];
                    p    = sa % sb;
                    e.hi = p[31:0];
                end
            end
        endcase
        return e;
    endfunction

    // Edges from E0 until the edge that raises done.
    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag;
        if (op[1]) return (b == 32'd0) ? 1 : 33;
`ifdef MDU_EARLY_TERM_EN
        mag = (op[0] && b[31]) ? (~b + 32'd1) : b;
        if (mag == 32'd0) return 1;
        for (int i = 31; i >= 0; i--) if (mag[i]) return i + 2;
`endif
        mag = a;
        return 33;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && u_if.done) begin
            exp_t e;
            n_done++;
            if (sb_q.size() == 0) begin
                check_val("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("sb_hi", u_if.hi, e.hi);
                check_val("sb_lo", u_if.lo, e.lo);
                check_val("sb_dbz", u_if.dbz, e.dbz);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        sb_q.push_back(model(op, a, b));
        @(negedge clk);
        u_if.start = 1'b1;
        u_if.op    = op;
        u_if.a     = a;
        u_if.b     = b;
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
        u_if.a     = $urandom;
        u_if.b     = $urandom;
        u_if.op    = 2'($urandom);
    endtask

    // Wait for done starting after edge first_k; returns edge index or 0 on timeout.
    task automatic wait_done(input int first_k, output int lat);
        lat = 0;
        for (int k = first_k; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (u_if.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        issue(op, a, b);
        check_val({tag, "_busy"}, u_if.busy, 1'b1);
        wait_done(1, lat);
        check_val({tag, "_lat"}, lat, exp_lat(op, a, b));
        check_val({tag, "_busy_end"}, u_if.busy, 1'b0);
        @(posedge clk);
        #1;
        check_val({tag, "_done_1cyc"}, u_if.done, 1'b0);
    endtask

    initial begin
        int lat;
        int done_before;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        u_if.start = 1'b0;
        u_if.op    = 2'b00;
        u_if.a     = '0;
        u_if.b     = '0;
        rst        = 1'b0;
        #23;
        check_val("rst_hi", u_if.hi, 32'd0);
        check_val("rst_lo", u_if.lo, 32'd0);
        check_val("rst_busy", u_if.busy, 1'b0);
        check_val("rst_done", u_if.done, 1'b0);
        check_val("rst_dbz", u_if.dbz, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_m3x7", 2'b01, 32'hFFFF_FFFD, 32'd7);
        run_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2);
        run_op("div_wrap", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_dbz", 2'b10, 32'h0000_1234, 32'd0);
        run_op("divu_10d3", 2'b10, 32'd10, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        check_val("hold_hi", u_if.hi, 32'd1);
        check_val("hold_lo", u_if.lo, 32'd3);
        run_op("div_dbz_s", 2'b11, 32'hFFFF_FFFB, 32'd0);
        run_op("mult_minsq", 2'b01, 32'h8000_0000, 32'h8000_0000);
        run_op("mult_x0", 2'b01, 32'h1357_9BDF, 32'd0);
        run_op("div_7dm2", 2'b11, 32'd7, 32'hFFFF_FFFE);
        run_op("divu_d1", 2'b10, 32'hFFFF_FFFF, 32'd1);
        run_op("mult_negb", 2'b01, 32'd1000, 32'hFFFF_FF00);

        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom >> $urandom_range(0, 31);
            run_op("rand", rop, ra, rb);
        end

        // A second start mid-operation must be dropped.
        done_before = n_done;
        issue(2'b00, 32'h1234_5678, 32'hFFFF_FFFF);
        repeat (9) @(posedge clk);
        @(negedge clk);
        u_if.start = 1'b1;
        u_if.op    = 2'b10;
        u_if.a     = 32'd99;
        u_if.b     = 32'd5;
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
        check_val("ign_busy", u_if.busy, 1'b1);
        wait_done(11, lat);
        check_val("ign_lat", lat, 33);
        repeat (40) @(posedge clk);
        #1;
        check_val("ign_one_done", n_done - done_before, 1);

        // Reset mid-divide aborts without a write.
        issue(2'b11, 32'h7FFF_FFFF, 32'd3);
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b0;
        sb_q.delete();
        done_before = n_done;
        #1;
        check_val("abort_busy", u_if.busy, 1'b0);
        check_val("abort_hi", u_if.hi, 32'd0);
        check_val("abort_lo", u_if.lo, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_val("abort_no_done", n_done - done_before, 0);
        run_op("post_rst", 2'b10, 32'd100, 32'd7);

        check_val("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
